matrix_result_writer: RTL and testbench

//  Downstream sink for the matrix_op_* engines (mul, add, ...). Accepts a write request

---
 rtl/matrix_result_writer.sv | 176 +++++++++++++++++
 tb/tb_matrix_result_writer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_writer.sv
// Result sink: writes metadata, then streams result words into a matrix block.
// Optional `MATRIX_WRITER_ZERO_FILL_EN clears the unused tail of the block.
module matrix_result_writer #(
  parameter int BLOCK_SIZE = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int META_WORDS = 4,
  parameter int CAPACITY   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_request,
  output logic                  write_ready,
  input  logic [2:0]            matrix_id,
  input  logic [7:0]            actual_rows,
  input  logic [7:0]            actual_cols,
  input  logic [7:0]            matrix_name [0:7],
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  writer_ready,
  output logic                  write_done,
  output logic                  write_error,
  output logic                  bram_wr_en,
  output logic [ADDR_WIDTH-1:0] bram_wr_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_META,
    S_STREAM,
    S_FILL,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]            id_q;
  logic [7:0]            rows_q;
  logic [7:0]            cols_q;
  logic [7:0]            name_q [0:7];
  logic                  err_q;
  logic [15:0]           total_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [15:0]           cnt_q, cnt_d;

  logic                  wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;

  logic [15:0]           prod;
  logic                  bad_shape;
  logic [ADDR_WIDTH-1:0] base_calc;
  logic [ADDR_WIDTH-1:0] meta_addr;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [DATA_WIDTH-1:0] meta_word;

  assign prod = {8'b0, rows_q} * {8'b0, cols_q};
  assign bad_shape = (rows_q == 8'd0) || (cols_q == 8'd0)
                  || (32'(prod) > 32'(CAPACITY));
  assign base_calc = ADDR_WIDTH'(32'(id_q) * BLOCK_SIZE);
  assign meta_addr = base_q + ADDR_WIDTH'(cnt_q);
  assign data_addr = base_q + ADDR_WIDTH'(META_WORDS)
                   + ADDR_WIDTH'(cnt_q);

  assign write_ready  = (state_q == S_IDLE);
  assign writer_ready = (state_q == S_STREAM);
  assign write_done   = (state_q == S_DONE);
  assign write_error  = (state_q == S_DONE) && err_q;

  // Word 0 holds the shape, words 1..2 the name packed little-endian.
  always_comb begin
    meta_word = '0;
    unique case (1'b1)
      cnt_q == 16'd0: meta_word[15:0] = {rows_q, cols_q};
      cnt_q == 16'd1: meta_word[31:0] = {name_q[3], name_q[2],
                                         name_q[1], name_q[0]};
      cnt_q == 16'd2: meta_word[31:0] = {name_q[7], name_q[6],
                                         name_q[5], name_q[4]};
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = bram_wr_addr;
    wr_data_d = bram_wr_data;
    unique case (state_q)
      S_IDLE: begin
        if (write_request) state_d = S_CHECK;
      end
      S_CHECK: begin
        cnt_d   = '0;
        state_d = bad_shape ? S_DONE : S_META;
      end
      S_META: begin
        wr_en_d   = 1'b1;
        wr_addr_d = meta_addr;
        wr_data_d = meta_word;
        if (cnt_q == 16'(META_WORDS - 1)) begin
          cnt_d   = '0;
          state_d = S_STREAM;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STREAM: begin
        if (data_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = data_addr;
          wr_data_d = data_in;
          cnt_d     = cnt_q + 16'd1;
          if (cnt_q == total_q - 16'd1) begin
`ifdef MATRIX_WRITER_ZERO_FILL_EN
            state_d = (total_q < 16'(CAPACITY)) ? S_FILL : S_FLUSH;
`else
            state_d = S_FLUSH;
`endif
          end
        end
      end
`ifdef MATRIX_WRITER_ZERO_FILL_EN
      S_FILL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = data_addr;
        wr_data_d = '0;
        cnt_d     = cnt_q + 16'd1;
        if (cnt_q == 16'(CAPACITY - 1)) state_d = S_FLUSH;
      end
`endif
      // One cycle for the final registered write to land before done.
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      id_q         <= '0;
      rows_q       <= '0;
      cols_q       <= '0;
      name_q       <= '{default: '0};
      err_q        <= 1'b0;
      total_q      <= '0;
      base_q       <= '0;
      cnt_q        <= '0;
      bram_wr_en   <= 1'b0;
      bram_wr_addr <= '0;
      bram_wr_data <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bram_wr_en   <= wr_en_d;
      bram_wr_addr <= wr_addr_d;
      bram_wr_data <= wr_data_d;
      if (state_q == S_IDLE && write_request) begin
        id_q   <= matrix_id;
        rows_q <= actual_rows;
        cols_q <= actual_cols;
        name_q <= matrix_name;
      end
      if (state_q == S_CHECK) begin
        err_q   <= bad_shape;
        total_q <= prod;
        base_q  <= base_calc;
      end
    end
  end

endmodule

// File: tb/tb_matrix_result_writer.sv
// Scoreboard bench for matrix_result_writer: expected BRAM writes and
// completions are queued by stimulus and checked by a negedge monitor.
module tb_matrix_result_writer;

  localparam int BS  = 64;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int MW  = 4;
  localparam int CAP = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          write_request = 1'b0;
  logic          write_ready;
  logic [2:0]    matrix_id = '0;
  logic [7:0]    actual_rows = '0;
  logic [7:0]    actual_cols = '0;
  logic [7:0]    matrix_name [0:7];
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          writer_ready;
  logic          write_done;
  logic          write_error;
  logic          bram_wr_en;
  logic [AW-1:0] bram_wr_addr;
  logic [DW-1:0] bram_wr_data;

  always #5 clk = ~clk;

  matrix_result_writer #(
    .BLOCK_SIZE(BS),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .META_WORDS(MW),
    .CAPACITY(CAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .write_request(write_request),
    .write_ready(write_ready),
    .matrix_id(matrix_id),
    .actual_rows(actual_rows),
    .actual_cols(actual_cols),
    .matrix_name(matrix_name),
    .data_in(data_in),
    .data_valid(data_valid),
    .writer_ready(writer_ready),
    .write_done(write_done),
    .write_error(write_error),
    .bram_wr_en(bram_wr_en),
    .bram_wr_addr(bram_wr_addr),
    .bram_wr_data(bram_wr_data)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t  wq[$];
  logic eq[$];
  int   total = 0;
  int   bad = 0;
  logic prev_en = 1'b0;

  localparam logic [63:0] NM_MULRES = 64'h0000_5345_524C_554D;
  localparam logic [63:0] NM_TINY   = 64'h0000_0000_0000_0041;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    wr_t  ew;
    logic ee;
    if (rst_n) begin
      if (bram_wr_en) begin
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write got=%0h:%0h want=none",
                   bram_wr_addr, bram_wr_data);
        end else begin
          ew = wq.pop_front();
          chk("wr_addr", 64'(bram_wr_addr), 64'(ew.a));
          chk("wr_data", 64'(bram_wr_data), 64'(ew.d));
        end
      end
      if (write_done) begin
        if (eq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done got=1 want=0");
        end else begin
          ee = eq.pop_front();
          chk("write_error", 64'(write_error), 64'(ee));
          if (!write_error) chk("done_after_wr", 64'(prev_en), 64'd1);
        end
      end
    end
    prev_en = bram_wr_en;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_meta(int id, int r, int c, logic [63:0] nm);
    logic [DW-1:0] w;
    for (int m = 0; m < MW; m++) begin
      w = '0;
      if (m == 0) w = DW'(r * 256 + c);
      else if (m < 3)
        for (int k = 0; k < 4; k++)
          w[8*k +: 8] = nm[8*(4*(m-1)+k) +: 8];
      wq.push_back(wr_t'{a: AW'(id*BS + m), d: w});
    end
  endtask

  task automatic push_data(int id, int k, int v);
    wq.push_back(wr_t'{a: AW'(id*BS + MW + k), d: DW'(v)});
  endtask

  task automatic send_req(int id, int r, int c, logic [63:0] nm);
    matrix_id   = 3'(id);
    actual_rows = 8'(r);
    actual_cols = 8'(c);
    for (int i = 0; i < 8; i++) matrix_name[i] = nm[8*i +: 8];
    write_request = 1'b1;
    step();
    write_request = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!write_ready && n < 100) begin
      step();
      n++;
    end
    if (!write_ready) begin
      total++;
      bad++;
      $display("FAIL idle_timeout got=busy want=idle");
    end
  endtask

  // gap: idle cycles between beats; poke: re-request during STREAM
  task automatic xfer(int id, int r, int c, logic [63:0] nm,
                      int gap, int vbase, bit poke, int stop_after);
    int n;
    int tot;
    tot = r * c;
    push_meta(id, r, c, nm);
    send_req(id, r, c, nm);
    n = 1;
    while (!writer_ready && n < 50) begin
      step();
      n++;
    end
    chk("req_to_ready", 64'(n), 64'(2 + MW));
    for (int k = 0; k < tot; k++) begin
      if (k == stop_after) return;
      data_valid = 1'b1;
      data_in    = DW'(vbase + k);
      if (poke && k == 1) write_request = 1'b1;
      push_data(id, k, vbase + k);
      step();
      data_valid    = 1'b0;
      write_request = 1'b0;
      if (k < tot - 1)
        for (int g = 0; g < gap; g++) begin
          chk("ready_held", 64'(writer_ready), 64'd1);
          step();
        end
    end
    chk("ready_drop", 64'(writer_ready), 64'd0);
`ifdef MATRIX_WRITER_ZERO_FILL_EN
    for (int k = tot; k < CAP; k++) push_data(id, k, 0);
`endif
    eq.push_back(1'b0);
    wait_idle();
  endtask

  task automatic err_req(int r, int c);
    eq.push_back(1'b1);
    send_req(5, r, c, NM_TINY);
    chk("err_not_done_early", 64'(write_done), 64'd0);
    step();
    chk("err_done", 64'(write_done), 64'd1);
    chk("err_flag", 64'(write_error), 64'd1);
    step();
    chk("err_back_idle", 64'(write_ready), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) matrix_name[i] = '0;
    #1;
    chk("rst_write_ready", 64'(write_ready), 64'd1);
    chk("rst_writer_ready", 64'(writer_ready), 64'd0);
    chk("rst_done", 64'(write_done), 64'd0);
    chk("rst_wr_en", 64'(bram_wr_en), 64'd0);
    chk("rst_wr_addr", 64'(bram_wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bram_wr_data), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // word0 of id 1 is 0x0203 at address 64
    xfer(1, 2, 3, NM_MULRES, 0, 1, 1'b0, -1);
    xfer(1, 2, 3, NM_MULRES, 2, 1, 1'b0, -1);
    err_req(0, 5);
    err_req(16, 16);
    err_req(7, 0);
    xfer(4, 4, 4, NM_TINY, 0, 100, 1'b0, -1);
    xfer(2, 1, 3, NM_TINY, 0, 50, 1'b1, -1);
    data_valid = 1'b1;
    data_in    = 32'hDEAD;
    step();
    step();
    data_valid = 1'b0;
    chk("idle_ignores_data", 64'(writer_ready), 64'd0);

    // abort after three beats; beat 3 lands before reset
    xfer(6, 2, 3, NM_MULRES, 0, 10, 1'b0, 3);
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_write_ready", 64'(write_ready), 64'd1);
    chk("abort_writer_ready", 64'(writer_ready), 64'd0);
    chk("abort_wr_en", 64'(bram_wr_en), 64'd0);
    chk("abort_wr_addr", 64'(bram_wr_addr), 64'd0);
    chk("abort_wr_data", 64'(bram_wr_data), 64'd0);
    chk("abort_done", 64'(write_done), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    xfer(6, 1, 1, NM_TINY, 0, 77, 1'b0, -1);

    xfer(3, 2, 2, NM_TINY, 0, 200, 1'b0, -1);
    xfer(3, 1, 2, NM_TINY, 1, 300, 1'b0, -1);

    repeat (5) step();
    chk("writes_drained", 64'(wq.size()), 64'd0);
    chk("dones_drained", 64'(eq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
